// File: rtl/ysyx_25040109_mdu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25040109_mdu_pkg
//   Shared constants for the sequential RV32M multiply/divide unit:
//   - XLEN / CNT_W       : datapath and iteration-counter widths
//   - MDU_MUL..MDU_REMU  : RV32M funct3 encodings
//   - S_IDLE/S_BUSY/S_DONE : sequencer state encoding
//   - mdu_fixup()        : sign correction / result select after the last step
// ----------------------------------------------------------------------------
package ysyx_25040109_mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Turns the unsigned magnitude result held in {hi, lo} into the final
    // architectural value. For multiplies {hi, lo} is the 64-bit product; for
    // divides hi is the remainder and lo the quotient.
    function automatic logic [XLEN-1:0] mdu_fixup(
        input logic [2:0]      op,
        input logic            sign_a,
        input logic            sign_b,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = {hi, lo};
        if (sign_a ^ sign_b) prod = -prod;
        quo = (sign_a ^ sign_b) ? -lo : lo;
        // Remainder follows the dividend's sign.
        rem = sign_a ? -hi : hi;
        if (op[2]) return op[1] ? rem : quo;
        return (op == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/ysyx_25040109_mdu_divstep.sv
// ----------------------------------------------------------------------------
// ysyx_25040109_mdu_divstep
//   One combinational restoring-division step on unsigned magnitudes.
//   Shifts the next dividend bit (MSB of quo) into the partial remainder,
//   subtracts the divisor when it fits, and shifts the quotient bit into quo.
//   Ports:
//     rem      in  XLEN  current partial remainder (always < divisor)
//     quo      in  XLEN  remaining dividend bits / quotient bits so far
//     divisor  in  XLEN  divisor magnitude (non-zero)
//     rem_nxt  out XLEN  next partial remainder
//     quo_nxt  out XLEN  next dividend/quotient word
// ----------------------------------------------------------------------------
module ysyx_25040109_mdu_divstep
    import ysyx_25040109_mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        trial = {rem, quo[XLEN-1]};
        diff  = trial - {1'b0, divisor};
        // Since rem < divisor, trial < 2*divisor: the top bit of diff is a
        // clean borrow flag meaning "divisor does not fit".
        if (!diff[XLEN]) begin
            rem_nxt = diff[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ysyx_25040109_mdu_seq.sv
// ----------------------------------------------------------------------------
// ysyx_25040109_mdu_seq
//   Multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   One request at a time: 32-step shift-add multiply or restoring divide on
//   operand magnitudes, followed by sign fixup. Divide-by-zero and signed
//   overflow complete without iterating.
//   Optional build macro: YSYX_25040109_MDU_FAST_MUL_EN -- multiplies use a
//   single 33x33 signed multiplier and complete without iterating.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     flush                 abort current op, wins over in_valid
//     in_valid/in_ready     request handshake (ready only in IDLE)
//     in_funct3/rs1/rs2/rd  op select, operands, destination tag
//     out_valid/out_ready   response handshake (valid only in DONE)
//     out_result/out_rd     result and its tag, stable while in DONE
//     busy                  high in BUSY or DONE, stalls the EXU
// ----------------------------------------------------------------------------
module ysyx_25040109_mdu_seq
    import ysyx_25040109_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    // hi_q: product high half (mul) or partial remainder (div)
    // lo_q: multiplier being consumed (mul) or dividend/quotient (div)
    // b_q : multiplicand magnitude (mul) or divisor magnitude (div)
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  b_q;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

    // ---------------- request decode ----------------
    logic            rs1_signed, rs2_signed, in_is_div;
    logic            in_sign_a, in_sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_by_zero, div_ovf, early;
    logic [XLEN-1:0] early_res;

    assign rs1_signed  = (in_funct3 == MDU_MULH) || (in_funct3 == MDU_MULHSU) ||
                         (in_funct3 == MDU_DIV)  || (in_funct3 == MDU_REM);
    assign rs2_signed  = (in_funct3 == MDU_MULH) || (in_funct3 == MDU_DIV) ||
                         (in_funct3 == MDU_REM);
    assign in_is_div   = in_funct3[2];
    assign in_sign_a   = rs1_signed & in_rs1[XLEN-1];
    assign in_sign_b   = rs2_signed & in_rs2[XLEN-1];
    // -0x80000000 wraps to itself, which is still the correct unsigned magnitude.
    assign mag_a       = in_sign_a ? -in_rs1 : in_rs1;
    assign mag_b       = in_sign_b ? -in_rs2 : in_rs2;
    assign div_by_zero = in_is_div && (in_rs2 == '0);
    assign div_ovf     = ((in_funct3 == MDU_DIV) || (in_funct3 == MDU_REM)) &&
                         (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);

`ifdef YSYX_25040109_MDU_FAST_MUL_EN
    // 33-bit operands carry the per-op sign extension; the low 66 bits of the
    // product of the sign-extended values equal the 33x33 signed product.
    logic signed [2*XLEN+1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{(XLEN+2){in_sign_a}}, in_rs1};
    assign fast_b    = {{(XLEN+2){in_sign_b}}, in_rs2};
    assign fast_prod = fast_a * fast_b;
    assign early     = div_by_zero || div_ovf || !in_is_div;
    always_comb begin
        early_res = '0;
        if (!in_is_div)
            early_res = (in_funct3 == MDU_MUL) ? fast_prod[XLEN-1:0]
                                               : fast_prod[2*XLEN-1:XLEN];
        else if (div_by_zero)
            early_res = in_funct3[1] ? in_rs1 : '1;
        else
            early_res = in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`else
    assign early = div_by_zero || div_ovf;
    always_comb begin
        early_res = '0;
        if (div_by_zero)
            early_res = in_funct3[1] ? in_rs1 : '1;
        else
            early_res = in_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`endif

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt;
    logic [XLEN-1:0] div_rem_nxt, div_quo_nxt;
    logic [XLEN-1:0] step_hi, step_lo;

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift {carry, hi, lo} right by one so the product fills in from the top.
    assign mul_sum    = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    assign mul_hi_nxt = mul_sum[XLEN:1];
    assign mul_lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};

    ysyx_25040109_mdu_divstep u_divstep (
        .rem     (hi_q),
        .quo     (lo_q),
        .divisor (b_q),
        .rem_nxt (div_rem_nxt),
        .quo_nxt (div_quo_nxt)
    );

    assign step_hi = op_q[2] ? div_rem_nxt : mul_hi_nxt;
    assign step_lo = op_q[2] ? div_quo_nxt : mul_lo_nxt;

    // ---------------- sequencer ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // The datapath registers are few, so they are cleared too; this
            // keeps a flushed op from leaving stale operands behind.
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_funct3;
                        sign_a_q <= in_sign_a;
                        sign_b_q <= in_sign_b;
                        out_rd   <= in_rd;
                        cnt_q    <= '0;
                        hi_q     <= '0;
                        if (early) begin
                            out_result <= early_res;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_BUSY;
                            lo_q    <= in_is_div ? mag_a : mag_b;
                            b_q     <= in_is_div ? mag_b : mag_a;
                        end
                    end
                end
                S_BUSY: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        out_result <= mdu_fixup(op_q, sign_a_q, sign_b_q, step_hi, step_lo);
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
